// File: rtl/b01_resp_capture.sv
// Trace capture for the b01 bench: records {obs, overflw, outp} after an __obs trigger and replays them over a read port.
// Optional MISR signature over the written records is enabled by defining B01_RESP_SIG_EN.
module b01_resp_capture #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic          stop,
    input  logic          dut_outp,
    input  logic          dut_overflw,
    input  logic          dut_obs,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [2:0]    rd_data,
    output logic [AW:0]   count,
    output logic [7:0]    ovf_hits,
    output logic [1:0]    state,
    output logic [15:0]   sig
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t      st;
    logic [2:0]  mem [DEPTH];
    logic [AW:0] rd_ptr;
    logic [AW:0] next_ptr;
    logic [AW:0] count_inc;
    logic [2:0]  record;
    logic        wr_en;

    assign record    = {dut_obs, dut_overflw, dut_outp};
    assign count_inc = count + ONE;
    assign state     = st;

    // A record is written on the trigger edge in ARMED and on every CAPTURE edge; stop suppresses both.
    always_comb begin
        wr_en = 1'b0;
        if (st == ARMED && !stop && dut_obs)
            wr_en = 1'b1;
        else if (st == CAPTURE && !stop)
            wr_en = 1'b1;
    end

    // Read port: a record moves when rd_valid && rd_ready at a rising edge;
    // rd_data and rd_valid then reflect the next record one cycle later.
    assign next_ptr = rd_ptr + {{AW{1'b0}}, (rd_valid & rd_ready)};

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[count[AW-1:0]] <= record;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            count    <= '0;
            ovf_hits <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (st)
                IDLE: begin
                    if (arm) begin
                        st       <= ARMED;
                        count    <= '0;
                        ovf_hits <= '0;
                        rd_ptr   <= '0;
                    end
                end
                ARMED: begin
                    if (stop) begin
                        st <= DONE;
                    end else if (dut_obs) begin
                        count <= ONE;
                        st    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        st <= DONE;
                    end else begin
                        count <= count_inc;
                        if (count_inc == FULL)
                            st <= DONE;
                    end
                end
                DONE: begin
                    if (arm) begin
                        st       <= ARMED;
                        count    <= '0;
                        ovf_hits <= '0;
                        rd_ptr   <= '0;
                    end else begin
                        rd_ptr   <= next_ptr;
                        rd_valid <= (next_ptr < count);
                        if (next_ptr < count)
                            rd_data <= mem[next_ptr[AW-1:0]];
                    end
                end
                default: st <= IDLE;
            endcase

            // Clears above only occur in IDLE/DONE, where wr_en is never set.
            if (wr_en && dut_overflw && ovf_hits != 8'hFF)
                ovf_hits <= ovf_hits + 8'd1;
        end
    end

`ifdef B01_RESP_SIG_EN
    logic [15:0] misr;
    logic        arm_take;

    assign arm_take = arm && (st == IDLE || st == DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            misr <= '0;
        else if (arm_take)
            misr <= 16'hFFFF;
        else if (wr_en)
            misr <= {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ {13'b0, record};
    end

    assign sig = misr;
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: doc/b01_resp_capture.md
Name: b01_resp_capture

Overview:
- Response-capture block for the b01 concolic bench, the observing end of the stimulus player.
- The player replays opcodes into line1/line2/__obs. This block samples the DUT responses (outp, overflw) together with __obs each cycle and stores them in a trace buffer.
- Host-side logic drains the buffer over a valid/ready read port after capture.
- Sits beside the b01 instance, clocked by the same clock.

Parameters:
- DEPTH, 16, number of trace records; power of two, >= 2.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clock  input  1  single clock; all sampling on rising edge.
- reset  input  1  asynchronous, active-low reset.
- arm  input  1  one-cycle pulse; clears the trace and waits for trigger.
- stop  input  1  one-cycle pulse; ends capture early.
- dut_outp  input  1  b01 outp.
- dut_overflw  input  1  b01 overflw.
- dut_obs  input  1  bench __obs; acts as trigger.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_valid  output  1  rd_data holds an unread record.
- rd_data  output  3  record {obs, overflw, outp}.
- count  output  AW+1  records stored (0..DEPTH).
- ovf_hits  output  8  records with overflw=1; saturates at 255.
- state  output  2  0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
- sig  output  16  response signature (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; count, ovf_hits, rd pointer = 0; rd_valid=0; rd_data=0; sig=0.
  - Buffer memory is not reset.
- IDLE:
  - arm -> ARMED; count, ovf_hits, rd pointer cleared.
  - stop ignored.
- ARMED:
  - Rising edge with dut_obs=1: record {1, overflw, outp} written at index 0; count=1 -> CAPTURE.
  - stop (takes priority over trigger) -> DONE with count=0.
  - arm ignored.
- CAPTURE:
  - Every rising edge writes {obs, overflw, outp} at index count; count++.
  - Trigger is not re-evaluated.
  - When the write makes count==DEPTH -> DONE. No wrap; later samples are dropped.
  - stop: that cycle is NOT recorded -> DONE.
  - arm ignored.
- ovf_hits increments on every written record with overflw=1; holds at 255.
- DONE, readout:
  - rd_valid=1 while rd pointer < count; rd_data = mem[rd pointer], registered.
  - rd_data updates the cycle after each transfer (rd_valid && rd_ready); rd pointer++.
  - rd_valid drops the cycle after the last record is taken. count=0 gives rd_valid=0 immediately.
  - rd_ready while rd_valid=0 has no effect.
  - arm in DONE (also mid-readout) -> ARMED: pointers cleared, rd_valid=0 next cycle; arm wins over a same-cycle transfer.
- Latency:
  - Sample to count update: 1 cycle.
  - DONE entry to first rd_valid: 1 cycle.
- Reset asserted mid-capture or mid-readout aborts to IDLE; partial data is discarded.

Optional Feature:
- Macro: B01_RESP_SIG_EN.
- Defined:
  - 16-bit MISR over written records, seeded to 16'hFFFF on arm.
  - Update per write: sig = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ {13'b0, record}.
  - Holds outside CAPTURE/trigger writes.
- Undefined: sig tied to 16'h0000 and no MISR logic is generated.

Test Plan:
- Reset during CAPTURE with count=5 -> state=0, count=0, rd_valid=0 within the same cycle (async).
- arm; dut_obs=0 for 3 cycles, then 1 -> first record is the trigger-cycle sample {1,o,p}; count reaches 16 after 16 edges; state=3; the 17th sample is not stored.
- arm; trigger; stop after 4 recorded edges -> count=4. Readout with rd_ready=1 gives exactly 4 records in order, then rd_valid=0.
- Readout with rd_ready toggling 1,0,1,0 -> rd_data is held stable while not accepted; no record is skipped or duplicated.
- overflw=1 on records 2,5,9 -> ovf_hits=3. A separate 300-record run (DEPTH=512 build, overflw=1 always) -> ovf_hits=255.
- With B01_RESP_SIG_EN: a single record 3'b101 from seed 16'hFFFF -> sig = 16'hFFFE ^ 16'h1021 ^ 16'h0005 = 16'hEFDA. Without the macro -> sig=0.
